mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one processor-side memory port (the ce/we/addr/width/data/ready interface that feeds `mem_axi`) among `NUM_REQ` requesters, e.g. the matcher, the executor, and a counter-update engine, so they can use a single AXI master. It provides round-robin arbitration, registers the winning request toward the downstream port, and routes the ready/read-data response back to the winner. It also provides a lock so a requester can perform an atomic read-modify-write, such as a counter-table increment, without interleaving.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_ce_i`  in  NUM_REQ  per-requester request valid. Held high until the matching `req_ready_o` is seen.
- `req_we_i`  in  NUM_REQ  per-requester write enable (1 = write).
- `req_lock_i`  in  NUM_REQ  when high, the requester keeps ownership after completion.
- `req_addr_i`  in  NUM_REQ*32  per-requester address. Slice i is bits [32i+31:32i].
- `req_width_i`  in  NUM_REQ*4  per-requester byte-lane width.
- `req_data_i`  in  NUM_REQ*32  per-requester write data.
- `req_ready_o`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `req_data_o`  out  32  read data, shared by all requesters. Valid only with `req_ready_o`.
- `mem_ce_o`  out  1  downstream request valid.
- `mem_we_o`  out  1  downstream write enable.
- `mem_addr_o`  out  32  downstream address.
- `mem_width_o`  out  4  downstream width.
- `mem_data_o`  out  32  downstream write data.
- `mem_data_i`  in  32  downstream read data.
- `mem_ready_i`  in  1  downstream one-cycle completion pulse.
- `grant_o`  out  NUM_REQ  one-hot current owner. All-zero when there is no owner.
- `busy_o`  out  1  high while in ISSUE.

## Operation
- FSM states: IDLE and ISSUE.
- IDLE behaviour:
  - Eligible set: `req_ce_i & ~served_mask`, where `served_mask` is all-zero except during the IDLE cycle that follows a completion.
  - If a lock owner exists, only that owner is eligible.
  - Round-robin search starts at `rr_ptr`. The first eligible index wins.
  - On a win: register `grant_o`, capture that requester's we/addr/width/data into the `mem_*_o` registers, assert `mem_ce_o`, and go to ISSUE.
- ISSUE behaviour:
  - `mem_*_o` are held stable.
  - When `mem_ready_i`=1:
    - `req_ready_o[g]`=1 and `req_data_o`=`mem_data_i`, combinational in the same cycle.
    - At the next edge: `mem_ce_o` goes to 0, state goes to IDLE, `rr_ptr`=(g+1) mod NUM_REQ.
    - Lock owner is set to g if `req_lock_i[g]`=1; otherwise it is cleared.
    - `served_mask`=one-hot(g) for one cycle, so a stale `req_ce_i[g]` cannot re-win.
- `grant_o` persists through the IDLE cycle only if a lock is held. Otherwise it is cleared at completion.
- Lock release rules:
  - The owner deasserts `req_lock_i` together with its final request. Ownership ends when that request completes.
  - If the owner drops both `req_ce_i` and `req_lock_i` while in IDLE, the lock clears that cycle and normal arbitration resumes in the same cycle.
- Boundary conditions:
  - `mem_ready_i` outside ISSUE is ignored. No `req_ready_o` is produced.
  - If `req_ce_i[g]` is withdrawn during ISSUE, the captured transaction still completes and the ready pulse is still issued.
  - With simultaneous requests from all requesters, each is served exactly once per NUM_REQ grants (no lock).
  - `rr_ptr` wraps from NUM_REQ-1 to 0.
- Reset (asynchronous, including mid-transaction):
  - Outputs cleared: `mem_ce_o`, `mem_we_o`, `mem_addr_o`, `mem_width_o`, `mem_data_o`, `grant_o`, `busy_o`, `req_ready_o` all 0; `req_data_o` is 0.
  - Internal state: `rr_ptr`=0, lock cleared, `served_mask`=0, state IDLE.
  - The downstream `mem_axi` shares `rst`, so an in-flight transaction is abandoned.

## Timing
- Request at IDLE cycle t: `mem_ce_o`=1 from cycle t+1.
- With `mem_ready_i` at cycle k: `req_ready_o` is asserted in cycle k, and `mem_ce_o`=0 in cycle k+1.
- Minimum gap: one cycle with `mem_ce_o` low between transactions. The next `mem_ce_o` is asserted at k+2.
- Back-to-back throughput: one transaction per (downstream latency + 2) cycles.
- `mem_*_o` change only on the IDLE→ISSUE edge.

## Test plan
- Single read, requester 2:
  - Stimulus: `req_addr_i[2]`=0x100; downstream returns 0xCAFEF00D three cycles after `mem_ce_o`.
  - Required: `mem_ce_o` rises 1 cycle after `req_ce_i`; `req_ready_o`=4'b0100 with `req_data_o`=0xCAFEF00D in the ready cycle; `mem_ce_o` low the next cycle.
- All four requesters continuously requesting, starting after reset:
  - Required: grant order 0,1,2,3,0.
  - Required: each `mem_addr_o` matches the grantee's `req_addr_i`.
- Lock, requester 1:
  - Stimulus: requester 1 reads 0x40 with lock=1, then writes 0x40 with lock=0, while requester 0 requests continuously.
  - Required: both accesses by requester 1 issue consecutively; requester 0 is granted only afterwards.
- Stale ce:
  - Stimulus: requester 3 holds `req_ce_i` for 1 cycle after its ready pulse; requester 0 is also requesting.
  - Required: requester 0 is granted next, and requester 3 is not re-issued.
- Reset mid-ISSUE:
  - Stimulus: assert `rst` low in the middle of ISSUE.
  - Required: `mem_ce_o`, `grant_o`, `busy_o` go to 0 immediately (asynchronously); after release, the first request is granted from index 0.
- Spurious `mem_ready_i` while in IDLE:
  - Required: no `req_ready_o` bit is set.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one processor-side memory port among NUM_REQ requesters,
// with a per-requester lock for atomic read-modify-write sequences.
module mem_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_ce_i,
  input  logic [NUM_REQ-1:0]      req_we_i,
  input  logic [NUM_REQ-1:0]      req_lock_i,
  input  logic [NUM_REQ*32-1:0]   req_addr_i,
  input  logic [NUM_REQ*4-1:0]    req_width_i,
  input  logic [NUM_REQ*32-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [31:0]             req_data_o,
  output logic                    mem_ce_o,
  output logic                    mem_we_o,
  output logic [31:0]             mem_addr_o,
  output logic [3:0]              mem_width_o,
  output logic [31:0]             mem_data_o,
  input  logic [31:0]             mem_data_i,
  input  logic                    mem_ready_i,
  output logic [NUM_REQ-1:0]      grant_o,
  output logic                    busy_o
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e               state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 lock_vld_q, lock_vld_d;
  logic [IW-1:0]        lock_idx_q, lock_idx_d;
  logic [NUM_REQ-1:0]   served_q, served_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic                 mem_ce_q, mem_ce_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [3:0]           mem_width_q, mem_width_d;
  logic [31:0]          mem_data_q, mem_data_d;

  logic [31:0]          addr_arr  [NUM_REQ];
  logic [3:0]           width_arr [NUM_REQ];
  logic [31:0]          data_arr  [NUM_REQ];

  logic [NUM_REQ-1:0]   elig_c;
  logic                 lock_rel_c;
  logic                 win_c;
  logic [IW-1:0]        win_idx_c;
  int unsigned          cand_c;
  logic                 done_c;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr_i[i*32 +: 32];
      width_arr[i] = req_width_i[i*4 +: 4];
      data_arr[i]  = req_data_i[i*32 +: 32];
    end
  end

  // Eligibility and round-robin search starting at rr_ptr_q.
  always_comb begin
    lock_rel_c = lock_vld_q && !req_ce_i[lock_idx_q] && !req_lock_i[lock_idx_q];
    elig_c     = req_ce_i & ~served_q;
    if (lock_vld_q && !lock_rel_c) begin
      elig_c = elig_c & (ONE << lock_idx_q);
    end
    win_c     = 1'b0;
    win_idx_c = '0;
    cand_c    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_c = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!win_c && elig_c[IW'(cand_c)]) begin
        win_c     = 1'b1;
        win_idx_c = IW'(cand_c);
      end
    end
  end

  assign done_c = (state_q == ISSUE) && mem_ready_i;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_vld_d  = lock_vld_q;
    lock_idx_d  = lock_idx_q;
    served_d    = '0;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    mem_ce_d    = mem_ce_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_width_d = mem_width_q;
    mem_data_d  = mem_data_q;
    case (state_q)
      IDLE: begin
        if (lock_rel_c) begin
          lock_vld_d = 1'b0;
          grant_d    = '0;
        end
        if (win_c) begin
          state_d     = ISSUE;
          grant_d     = ONE << win_idx_c;
          gidx_d      = win_idx_c;
          mem_ce_d    = 1'b1;
          mem_we_d    = req_we_i[win_idx_c];
          mem_addr_d  = addr_arr[win_idx_c];
          mem_width_d = width_arr[win_idx_c];
          mem_data_d  = data_arr[win_idx_c];
        end
      end
      ISSUE: begin
        // Served mask blocks a stale ce from the just-completed requester for one cycle.
        if (mem_ready_i) begin
          state_d    = IDLE;
          mem_ce_d   = 1'b0;
          rr_ptr_d   = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
          lock_vld_d = req_lock_i[gidx_q];
          lock_idx_d = gidx_q;
          served_d   = grant_q;
          if (!req_lock_i[gidx_q]) begin
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lock_vld_q  <= 1'b0;
      lock_idx_q  <= '0;
      served_q    <= '0;
      grant_q     <= '0;
      gidx_q      <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_width_q <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_vld_q  <= lock_vld_d;
      lock_idx_q  <= lock_idx_d;
      served_q    <= served_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_width_q <= mem_width_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign mem_ce_o    = mem_ce_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_width_o = mem_width_q;
  assign mem_data_o  = mem_data_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q == ISSUE);
  // Completion response is combinational so the requester sees it in the ready cycle.
  assign req_ready_o = done_c ? grant_q : '0;
  assign req_data_o  = done_c ? mem_data_i : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of round-robin/lock transactions plus
// hand-written sequences for lock, stale ce, spurious ready and async reset.
module tb_mem_arbiter;

  localparam int unsigned N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_ce_i, req_we_i, req_lock_i;
  logic [N*32-1:0]   req_addr_i, req_data_i;
  logic [N*4-1:0]    req_width_i;
  logic [N-1:0]      req_ready_o;
  logic [31:0]       req_data_o;
  logic              mem_ce_o, mem_we_o;
  logic [31:0]       mem_addr_o, mem_data_o;
  logic [3:0]        mem_width_o;
  logic [31:0]       mem_data_i;
  logic              mem_ready_i;
  logic [N-1:0]      grant_o;
  logic              busy_o;

  logic [31:0] addr_a  [N];
  logic [31:0] data_a  [N];
  logic [3:0]  width_a [N];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_ce_i(req_ce_i), .req_we_i(req_we_i), .req_lock_i(req_lock_i),
    .req_addr_i(req_addr_i), .req_width_i(req_width_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .req_data_o(req_data_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ready_i(mem_ready_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr_i[i*32 +: 32] = addr_a[i];
      req_data_i[i*32 +: 32] = data_a[i];
      req_width_i[i*4 +: 4]  = width_a[i];
    end
  end

  typedef struct {
    logic [3:0]  ce;
    logic [3:0]  lock;
    int          lat;
    logic [31:0] rdata;
    logic [3:0]  exp_g;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic apply_reset();
    req_ce_i    = '0;
    req_lock_i  = '0;
    mem_ready_i = 1'b0;
    mem_data_i  = '0;
    rst         = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic init_reqs();
    for (int i = 0; i < N; i++) begin
      addr_a[i]  = 32'h40 * 32'(i + 2);
      data_a[i]  = 32'hD000_0000 + 32'(i);
      width_a[i] = 4'(i + 1);
    end
    req_we_i = 4'b1010;
  endtask

  // Waits (bounded) for mem_ce_o; returns cycles waited.
  task automatic wait_issue(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!mem_ce_o && n < 8);
    chk({tag, " issued"}, 32'(mem_ce_o), 32'd1);
  endtask

  task automatic complete(input string tag, input int lat, input logic [31:0] rdata,
                          input logic [3:0] exp_rdy);
    repeat (lat) step();
    mem_data_i  = rdata;
    mem_ready_i = 1'b1;
    #1;
    chk({tag, " ready"}, 32'(req_ready_o), 32'(exp_rdy));
    chk({tag, " rdata"}, req_data_o, rdata);
    step();
    mem_ready_i = 1'b0;
    mem_data_i  = '0;
  endtask

  task automatic run_txn(input string tag, input logic [3:0] ce, input logic [3:0] lock,
                         input int lat, input logic [31:0] rdata, input logic [3:0] exp_g);
    int n;
    int g;
    g = oh2idx(exp_g);
    req_ce_i   = ce;
    req_lock_i = lock;
    wait_issue(tag, n);
    chk({tag, " delay"}, 32'(n), 32'd1);
    chk({tag, " grant"}, 32'(grant_o), 32'(exp_g));
    chk({tag, " busy"},  32'(busy_o), 32'd1);
    chk({tag, " addr"},  mem_addr_o, addr_a[g]);
    chk({tag, " we"},    32'(mem_we_o), 32'(req_we_i[g]));
    chk({tag, " width"}, 32'(mem_width_o), 32'(width_a[g]));
    chk({tag, " wdata"}, mem_data_o, data_a[g]);
    complete(tag, lat, rdata, exp_g);
    chk({tag, " gap ce"}, 32'(mem_ce_o), 32'd0);
    chk({tag, " post grant"}, 32'(grant_o), lock[g] ? 32'(exp_g) : 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vt[0]  = '{4'b1111, 4'b0000, 1, 32'h1111_0000, 4'b0001};
    vt[1]  = '{4'b1111, 4'b0000, 2, 32'h1111_0001, 4'b0010};
    vt[2]  = '{4'b1111, 4'b0000, 1, 32'h1111_0002, 4'b0100};
    vt[3]  = '{4'b1111, 4'b0000, 4, 32'h1111_0003, 4'b1000};
    vt[4]  = '{4'b1111, 4'b0000, 1, 32'h1111_0004, 4'b0001};
    vt[5]  = '{4'b1001, 4'b0000, 2, 32'h1111_0005, 4'b1000};
    vt[6]  = '{4'b0110, 4'b0000, 1, 32'h1111_0006, 4'b0010};
    vt[7]  = '{4'b0011, 4'b0000, 3, 32'h1111_0007, 4'b0001};
    vt[8]  = '{4'b0010, 4'b0010, 1, 32'h1111_0008, 4'b0010};
    vt[9]  = '{4'b0100, 4'b0000, 2, 32'h1111_0009, 4'b0100};
    vt[10] = '{4'b1111, 4'b0000, 1, 32'h1111_000A, 4'b1000};
    vt[11] = '{4'b1111, 4'b0000, 1, 32'h1111_000B, 4'b0001};

    init_reqs();
    apply_reset();
    chk("reset mem_ce",  32'(mem_ce_o), 32'd0);
    chk("reset grant",   32'(grant_o), 32'd0);
    chk("reset busy",    32'(busy_o), 32'd0);
    chk("reset addr",    mem_addr_o, 32'd0);
    chk("reset ready",   32'(req_ready_o), 32'd0);
    chk("reset rdata",   req_data_o, 32'd0);

    // Single read by requester 2 at 0x100, data three cycles after mem_ce_o.
    run_txn("single", 4'b0100, 4'b0000, 3, 32'hCAFE_F00D, 4'b0100);
    chk("single addr 0x100", mem_addr_o, 32'h100);
    req_ce_i = '0;

    apply_reset();
    for (int v = 0; v < 12; v++) begin
      run_txn($sformatf("vec%0d", v), vt[v].ce, vt[v].lock, vt[v].lat, vt[v].rdata, vt[v].exp_g);
    end
    req_ce_i   = '0;
    req_lock_i = '0;

    // Locked read-modify-write by requester 1 while requester 0 waits.
    apply_reset();
    addr_a[1]   = 32'h40;
    req_we_i[1] = 1'b0;
    req_ce_i    = 4'b0010;
    req_lock_i  = 4'b0010;
    wait_issue("lock rd", n);
    chk("lock rd grant", 32'(grant_o), 32'h2);
    chk("lock rd addr", mem_addr_o, 32'h40);
    chk("lock rd we", 32'(mem_we_o), 32'd0);
    req_ce_i[0] = 1'b1;
    complete("lock rd", 2, 32'h5, 4'b0010);
    req_we_i[1]   = 1'b1;
    data_a[1]     = 32'h6;
    req_lock_i[1] = 1'b0;
    chk("lock hold grant", 32'(grant_o), 32'h2);
    wait_issue("lock wr", n);
    chk("lock wr grant", 32'(grant_o), 32'h2);
    chk("lock wr we", 32'(mem_we_o), 32'd1);
    chk("lock wr addr", mem_addr_o, 32'h40);
    chk("lock wr data", mem_data_o, 32'h6);
    complete("lock wr", 1, 32'h0, 4'b0010);
    req_ce_i[1] = 1'b0;
    chk("lock released grant", 32'(grant_o), 32'h0);
    wait_issue("after lock", n);
    chk("after lock grant", 32'(grant_o), 32'h1);
    complete("after lock", 1, 32'h7, 4'b0001);
    req_ce_i = '0;
    init_reqs();

    // Stale ce from requester 3 alone (rr_ptr wraps to 0, so only the mask blocks it).
    req_ce_i = 4'b1000;
    wait_issue("stale solo", n);
    chk("stale solo grant", 32'(grant_o), 32'h8);
    complete("stale solo", 1, 32'h8, 4'b1000);
    step();
    chk("stale solo no reissue", 32'(mem_ce_o), 32'd0);
    req_ce_i = '0;
    step();
    chk("stale solo idle", 32'(busy_o), 32'd0);

    // Stale ce from requester 3 while requester 0 also requests.
    req_ce_i = 4'b1000;
    wait_issue("stale r3", n);
    chk("stale r3 grant", 32'(grant_o), 32'h8);
    req_ce_i[0] = 1'b1;
    complete("stale r3", 2, 32'h9, 4'b1000);
    wait_issue("stale next", n);
    req_ce_i[3] = 1'b0;
    chk("stale next grant", 32'(grant_o), 32'h1);
    chk("stale next addr", mem_addr_o, addr_a[0]);
    complete("stale next", 1, 32'hA, 4'b0001);
    req_ce_i = '0;

    // Spurious mem_ready_i while idle.
    step();
    mem_data_i  = 32'hDEAD_BEEF;
    mem_ready_i = 1'b1;
    #1;
    chk("spurious ready", 32'(req_ready_o), 32'd0);
    chk("spurious rdata", req_data_o, 32'd0);
    step();
    mem_ready_i = 1'b0;
    chk("spurious no issue", 32'(mem_ce_o), 32'd0);

    // Reset in the middle of ISSUE, with rr_ptr advanced away from 0.
    run_txn("pre reset", 4'b0100, 4'b0000, 1, 32'hB, 4'b0100);
    req_ce_i = 4'b0010;
    wait_issue("mid reset", n);
    step();
    rst = 1'b0;
    #1;
    chk("async rst mem_ce", 32'(mem_ce_o), 32'd0);
    chk("async rst grant", 32'(grant_o), 32'd0);
    chk("async rst busy", 32'(busy_o), 32'd0);
    step();
    rst      = 1'b1;
    req_ce_i = 4'b1111;
    wait_issue("post reset", n);
    chk("post reset grant", 32'(grant_o), 32'h1);
    chk("post reset addr", mem_addr_o, addr_a[0]);
    complete("post reset", 1, 32'hC, 4'b0001);
    req_ce_i = '0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
